// File: rtl/mem_access_stage_ctrl_if.sv
// rtl/mem_access_stage_ctrl_if.sv - MEM stage handshake, data-memory and MEM/WB signal bundle
interface mem_access_stage_ctrl_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16
);
  logic                   in_valid;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0]  alu_result;
  logic [DATA_WIDTH-1:0]  store_data;
  logic [ADDR_WIDTH-1:0]  input_addr;
  logic                   stall_out;
  logic                   mem_re;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instruction;
  logic [DATA_WIDTH-1:0]  out_data;

  modport master (
    output in_valid, instruction, alu_result, store_data, input_addr, mem_rdata,
    input  stall_out, mem_re, mem_we, mem_addr, mem_wdata, out_valid, out_instruction, out_data
  );

  modport slave (
    input  in_valid, instruction, alu_result, store_data, input_addr, mem_rdata,
    output stall_out, mem_re, mem_we, mem_addr, mem_wdata, out_valid, out_instruction, out_data
  );
endinterface

// File: rtl/mem_access_stage_ctrl.sv
// rtl/mem_access_stage_ctrl.sv - MEM stage controller: decode, issue memory request, wait, respond
module mem_access_stage_ctrl #(
  parameter int INSTR_WIDTH  = 20,
  parameter int OPCODE_MSB   = 19,
  parameter int OPCODE_WIDTH = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_LATENCY  = 2,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE = 4'b1100,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'b1011,
  parameter logic [OPCODE_WIDTH-1:0] OP_COPY  = 4'b1111
) (
  input logic                    clock,
  input logic                    reset,
  mem_access_stage_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [INSTR_WIDTH-1:0]  h_instr;
  logic [DATA_WIDTH-1:0]   h_alu, h_sd;
  logic [ADDR_WIDTH-1:0]   h_ia;
  logic [ADDR_WIDTH-1:0]   addr_q, addr;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata;
  logic [OPCODE_WIDTH-1:0] op;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic                    is_mem, stall, accept;
  logic                    re, we, ov;
  logic [DATA_WIDTH-1:0]   od;

  assign op       = h_instr[OPCODE_MSB -: OPCODE_WIDTH];
  assign is_mem   = (op == OP_LOAD) || (op == OP_COPY);
  assign src_addr = (op == OP_COPY) ? h_ia : ADDR_WIDTH'(h_alu);
  assign stall    = ((state == ISSUE) && is_mem) || (state == WAIT);
  assign accept   = bus.in_valid && !stall;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    re        = 1'b0;
    we        = 1'b0;
    ov        = 1'b0;
    od        = h_alu;
    addr      = addr_q;
    wdata     = wdata_q;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (is_mem) begin
          re   = 1'b1;
          addr = src_addr;
          if (MEM_LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end else begin
          if (op == OP_STORE) begin
            we    = 1'b1;
            addr  = src_addr;
            wdata = h_sd;
          end
          ov        = 1'b1;
          state_nxt = accept ? ISSUE : IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        ov        = 1'b1;
        od        = bus.mem_rdata;
        state_nxt = accept ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // addr_q/wdata_q keep the last driven bus values so mem_addr/mem_wdata hold between strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      h_instr <= '0;
      h_alu   <= '0;
      h_sd    <= '0;
      h_ia    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr;
      wdata_q <= wdata;
      if (accept) begin
        h_instr <= bus.instruction;
        h_alu   <= bus.alu_result;
        h_sd    <= bus.store_data;
        h_ia    <= bus.input_addr;
      end
    end
  end

  assign bus.stall_out       = stall;
  assign bus.mem_re          = re;
  assign bus.mem_we          = we;
  assign bus.mem_addr        = addr;
  assign bus.mem_wdata       = wdata;
  assign bus.out_valid       = ov;
  assign bus.out_instruction = h_instr;
  assign bus.out_data        = od;
endmodule

// File: tb/tb_mem_access_stage_ctrl.sv
// tb/tb_mem_access_stage_ctrl.sv - self-checking bench, latency 2 and latency 1 instances side by side
module tb_mem_access_stage_ctrl;
  logic clock;
  logic reset0, reset1;

  mem_access_stage_ctrl_if bus0 ();
  mem_access_stage_ctrl_if bus1 ();

  mem_access_stage_ctrl #(.MEM_LATENCY(2)) dut0 (.clock(clock), .reset(reset0), .bus(bus0));
  mem_access_stage_ctrl #(.MEM_LATENCY(1)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          kind;  // 0 instruction, 1 bubble, 2 reset (with in_valid high)
    logic [19:0] ins;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [15:0] ia;
  } ent_t;

  typedef struct {
    logic        stall, re, we, ov;
    logic [15:0] addr, wdata, odata;
    logic [19:0] oinst;
  } outs_t;

  ent_t        prog[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          lat[2] = '{2, 1};
  int          ptr[2];
  bit          act[2];
  int          acc_c[2];
  logic [19:0] h_ins[2];
  logic [15:0] h_alu[2], h_sd[2], h_ia[2];
  logic [15:0] last_addr[2], last_wd[2];
  int          pend_c[2];
  logic [15:0] pend_d[2];
  int          ov_n[2], st_n[2], rd_n[2], wr_n[2];
  logic [15:0] ov_d[2][16];
  logic [19:0] ov_i[2][16];
  logic [15:0] rd_a[2][8];
  logic [15:0] wr_a[2], wr_d[2];

  function automatic logic [15:0] mem_f(logic [15:0] a);
    return (a == 16'h0010) ? 16'h5A5A : (a ^ 16'hA5A5);
  endfunction

  function automatic outs_t get_outs(int k);
    outs_t o;
    if (k == 0) begin
      o.stall = bus0.stall_out; o.re = bus0.mem_re; o.we = bus0.mem_we; o.ov = bus0.out_valid;
      o.addr = bus0.mem_addr; o.wdata = bus0.mem_wdata; o.odata = bus0.out_data; o.oinst = bus0.out_instruction;
    end else begin
      o.stall = bus1.stall_out; o.re = bus1.mem_re; o.we = bus1.mem_we; o.ov = bus1.out_valid;
      o.addr = bus1.mem_addr; o.wdata = bus1.mem_wdata; o.odata = bus1.out_data; o.oinst = bus1.out_instruction;
    end
    return o;
  endfunction

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  task automatic add(int kind, logic [19:0] ins, logic [15:0] alu, logic [15:0] sd, logic [15:0] ia);
    ent_t e;
    e.kind = kind; e.ins = ins; e.alu = alu; e.sd = sd; e.ia = ia;
    prog.push_back(e);
  endtask

  task automatic present(int k);
    ent_t        e;
    logic        r, iv;
    logic [15:0] rd;
    e = '{kind: 1, ins: '0, alu: '0, sd: '0, ia: '0};
    if (ptr[k] < prog.size()) e = prog[ptr[k]];
    r  = (e.kind == 2);
    iv = (e.kind != 1);
    rd = (cyc == pend_c[k]) ? pend_d[k] : 16'hDEAD;
    if (k == 0) begin
      reset0 = r; bus0.in_valid = iv; bus0.instruction = e.ins; bus0.alu_result = e.alu;
      bus0.store_data = e.sd; bus0.input_addr = e.ia; bus0.mem_rdata = rd;
    end else begin
      reset1 = r; bus1.in_valid = iv; bus1.instruction = e.ins; bus1.alu_result = e.alu;
      bus1.store_data = e.sd; bus1.input_addr = e.ia; bus1.mem_rdata = rd;
    end
  endtask

  // Occupancy model: an instruction accepted in cycle a owns cycles a+1 .. a+occ
  task automatic step_model(int k);
    outs_t       d;
    ent_t        e;
    logic [3:0]  op;
    bit          have, mem, live, e_re, e_we, e_stall, e_ov, is_rst, iv;
    int          occ, o;
    logic [15:0] src, e_addr, e_wd;
    d    = get_outs(k);
    have = ptr[k] < prog.size();
    e    = '{kind: 1, ins: '0, alu: '0, sd: '0, ia: '0};
    if (have) e = prog[ptr[k]];
    op      = h_ins[k][19:16];
    mem     = (op == 4'hB) || (op == 4'hF);
    occ     = mem ? lat[k] + 1 : 1;
    o       = cyc - acc_c[k];
    live    = act[k] && o >= 1 && o <= occ;
    src     = (op == 4'hF) ? h_ia[k] : h_alu[k];
    e_re    = live && o == 1 && mem;
    e_we    = live && o == 1 && op == 4'hC;
    e_addr  = (e_re || e_we) ? src : last_addr[k];
    e_wd    = e_we ? h_sd[k] : last_wd[k];
    e_stall = live && mem && o <= lat[k];
    e_ov    = live && o == occ;

    chk("stall_out", k, 32'(d.stall), 32'(e_stall));
    chk("mem_re", k, 32'(d.re), 32'(e_re));
    chk("mem_we", k, 32'(d.we), 32'(e_we));
    chk("mem_addr", k, 32'(d.addr), 32'(e_addr));
    chk("mem_wdata", k, 32'(d.wdata), 32'(e_wd));
    chk("out_valid", k, 32'(d.ov), 32'(e_ov));
    chk("out_instruction", k, 32'(d.oinst), 32'(h_ins[k]));
    if (e_ov) chk("out_data", k, 32'(d.odata), 32'(mem ? mem_f(src) : h_alu[k]));

    if (d.ov === 1'b1) begin
      if (ov_n[k] < 16) begin ov_d[k][ov_n[k]] = d.odata; ov_i[k][ov_n[k]] = d.oinst; end
      ov_n[k]++;
    end
    if (d.stall === 1'b1) st_n[k]++;
    if (d.re === 1'b1) begin
      if (rd_n[k] < 8) rd_a[k][rd_n[k]] = d.addr;
      rd_n[k]++;
    end
    if (d.we === 1'b1 && wr_n[k] == 0) begin wr_a[k] = d.addr; wr_d[k] = d.wdata; wr_n[k]++; end

    is_rst = have && e.kind == 2;
    iv     = have && e.kind != 1;
    if (is_rst) begin
      act[k] = 0; h_ins[k] = '0; h_alu[k] = '0; h_sd[k] = '0; h_ia[k] = '0;
      last_addr[k] = '0; last_wd[k] = '0;
    end else begin
      if (e_re) begin pend_c[k] = cyc + lat[k]; pend_d[k] = mem_f(e_addr); end
      last_addr[k] = e_addr;
      last_wd[k]   = e_wd;
      if (live && o >= occ) act[k] = 0;
      if (iv && !e_stall) begin
        act[k] = 1; acc_c[k] = cyc;
        h_ins[k] = e.ins; h_alu[k] = e.alu; h_sd[k] = e.sd; h_ia[k] = e.ia;
      end
    end
    if (have && (e.kind != 0 || (iv && !e_stall))) ptr[k]++;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0; act[k] = 0; acc_c[k] = -100; h_ins[k] = '0; h_alu[k] = '0; h_sd[k] = '0; h_ia[k] = '0;
      last_addr[k] = '0; last_wd[k] = '0; pend_c[k] = -100; pend_d[k] = '0;
      ov_n[k] = 0; st_n[k] = 0; rd_n[k] = 0; wr_n[k] = 0;
    end

    add(0, 20'hC1234, 16'h0040, 16'hBEEF, 16'h0000);  // STORE
    add(1, '0, '0, '0, '0);
    add(0, 20'hB0000, 16'h0010, 16'h0000, 16'h0000);  // LOAD
    add(0, 20'hF0000, 16'h0003, 16'h0000, 16'h0077);  // COPY INPUT
    add(1, '0, '0, '0, '0);
    add(0, 20'h10005, 16'h1111, 16'h0000, 16'h0000);  // back-to-back: ADD STORE LOAD ADD
    add(0, 20'hC0001, 16'h0022, 16'h3333, 16'h0000);
    add(0, 20'hB0002, 16'h0010, 16'h0000, 16'h0000);
    add(0, 20'h10003, 16'h4444, 16'h0000, 16'h0000);
    add(1, '0, '0, '0, '0);
    add(0, 20'hB0009, 16'h0030, 16'h0000, 16'h0000);  // LOAD abandoned by reset
    add(1, '0, '0, '0, '0);
    add(2, 20'h10007, 16'h7777, 16'h0000, 16'h0000);
    add(2, 20'h10007, 16'h7777, 16'h0000, 16'h0000);
    add(0, 20'h1000A, 16'h0ABC, 16'h0000, 16'h0000);

    reset0 = 1'b1; reset1 = 1'b1;
    bus0.in_valid = 1'b0; bus0.instruction = '0; bus0.alu_result = '0; bus0.store_data = '0;
    bus0.input_addr = '0; bus0.mem_rdata = '0;
    bus1.in_valid = 1'b0; bus1.instruction = '0; bus1.alu_result = '0; bus1.store_data = '0;
    bus1.input_addr = '0; bus1.mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      outs_t d;
      d = get_outs(k);
      chk("reset stall_out", k, 32'(d.stall), 32'd0);
      chk("reset strobes", k, 32'({d.re, d.we}), 32'd0);
      chk("reset mem_addr", k, 32'(d.addr), 32'd0);
      chk("reset mem_wdata", k, 32'(d.wdata), 32'd0);
      chk("reset out_valid", k, 32'(d.ov), 32'd0);
      chk("reset out_instruction", k, 32'(d.oinst), 32'd0);
    end
    @(posedge clock);
    #1;

    cyc = 0;
    while ((ptr[0] < prog.size() || ptr[1] < prog.size() || cyc < 8 + prog.size()) && cyc < 400) begin
      present(0);
      present(1);
      @(negedge clock);
      step_model(0);
      step_model(1);
      @(posedge clock);
      #1;
      cyc++;
    end
    if (cyc >= 400) begin
      checks++; errors++;
      $display("FAIL timeout: program not consumed, ptr0=%0d ptr1=%0d expected %0d", ptr[0], ptr[1], prog.size());
    end
    for (int n = 0; n < 6; n++) begin
      present(0);
      present(1);
      @(negedge clock);
      step_model(0);
      step_model(1);
      @(posedge clock);
      #1;
      cyc++;
    end

    chk("pulse count", 0, 32'(ov_n[0]), 32'd8);
    chk("pulse count", 1, 32'(ov_n[1]), 32'd9);
    chk("stall cycles", 0, 32'(st_n[0]), 32'd8);
    chk("stall cycles", 1, 32'(st_n[1]), 32'd4);
    chk("first store addr", 0, 32'(wr_a[0]), 32'h0040);
    chk("first store data", 0, 32'(wr_d[0]), 32'hBEEF);
    chk("read count", 0, 32'(rd_n[0]), 32'd4);
    chk("copy read addr", 0, 32'(rd_a[0][1]), 32'h0077);
    chk("copy read addr", 1, 32'(rd_a[1][1]), 32'h0077);
    for (int k = 0; k < 2; k++) begin
      chk("store result", k, 32'(ov_d[k][0]), 32'h0040);
      chk("store instr", k, 32'(ov_i[k][0]), 32'hC1234);
      chk("load result", k, 32'(ov_d[k][1]), 32'h5A5A);
      chk("load instr", k, 32'(ov_i[k][1]), 32'hB0000);
      chk("copy result", k, 32'(ov_d[k][2]), 32'hA5D2);
      chk("b2b add", k, 32'(ov_d[k][3]), 32'h1111);
      chk("b2b store", k, 32'(ov_d[k][4]), 32'h0022);
      chk("b2b load", k, 32'(ov_d[k][5]), 32'h5A5A);
      chk("b2b add2", k, 32'(ov_d[k][6]), 32'h4444);
      chk("b2b add2 instr", k, 32'(ov_i[k][6]), 32'h10003);
    end
    chk("post-reset add", 0, 32'(ov_d[0][7]), 32'h0ABC);
    chk("load at reset", 1, 32'(ov_d[1][7]), 32'hA595);
    chk("post-reset add", 1, 32'(ov_d[1][8]), 32'h0ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
